// File: rtl/hv_job_ctrl_pkg.sv
// Shared types and constants for the hypervector job sequencer: state encoding,
// register map, CTRL/STATUS/IRQ_EN bit positions and parameter reset values.
package hv_job_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GEN  = 3'd1,
    GAP  = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } job_state_e;

  localparam logic [3:0] REG_CTRL     = 4'h0;
  localparam logic [3:0] REG_STATUS   = 4'h1;
  localparam logic [3:0] REG_ITEM_NUM = 4'h2;
  localparam logic [3:0] REG_ADDR_I   = 4'h3;
  localparam logic [3:0] REG_ADDR_J   = 4'h4;
  localparam logic [3:0] REG_REM      = 4'h5;
  localparam logic [3:0] REG_BEATS    = 4'h6;
  localparam logic [3:0] REG_TIMEOUT  = 4'h7;
  localparam logic [3:0] REG_IRQ_EN   = 4'h8;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_ABORT_BIT   = 1;
  localparam int STAT_DONE_BIT    = 4;
  localparam int STAT_ERR_BIT     = 5;
  localparam int STAT_ABORTED_BIT = 6;
  localparam int STAT_REJ_BIT     = 7;
  localparam int IRQ_DONE_BIT     = 0;
  localparam int IRQ_ERR_BIT      = 1;

  localparam int unsigned ITEM_NUM_RST = 1000;
  localparam int unsigned ADDR_I_RST   = 9;
  localparam int unsigned ADDR_J_RST   = 2;
  localparam int unsigned REM_RST      = 0;

endpackage

// File: rtl/hv_job_watchdog.sv
// RUN-phase watchdog: counts RUN cycles since entry or the last accepted beat
// and flags expiry when the count equals a non-zero timeout.
module hv_job_watchdog #(
  parameter int TMO_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_en,
  input  logic [TMO_W-1:0] timeout,
  output logic             expired
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = count_en && (timeout != '0) && (cnt_q == timeout);

endmodule

// File: rtl/hv_job_ctrl.sv
// Job sequencer: holds job parameters, runs GEN -> GAP -> RUN -> DONE and counts
// accepted output beats. Optional RUN watchdog under HV_JOB_CTRL_WATCHDOG_EN.
module hv_job_ctrl
  import hv_job_ctrl_pkg::*;
#(
  parameter int ITEM_W = 16,
  parameter int ADDR_W = 20,
  parameter int REM_W  = 5,
  parameter int BEAT_W = 16,
  parameter int TMO_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic              cfg_re,
  input  logic [3:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  input  logic              stream_valid,
  input  logic              stream_ready,
  input  logic              stream_last,
  output logic              gen,
  output logic              run,
  output logic [ITEM_W-1:0] item_a,
  output logic [ITEM_W-1:0] item_memory_num,
  output logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_j,
  output logic [REM_W-1:0]  remainder,
  output logic              busy,
  output logic              irq
);

  job_state_e        state_q, state_d;
  logic [ITEM_W-1:0] item_a_q, item_a_d;
  logic [ITEM_W-1:0] item_num_q, item_num_d;
  logic [ADDR_W-1:0] addr_i_q, addr_i_d;
  logic [ADDR_W-1:0] addr_j_q, addr_j_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic              done_q, done_d, err_q, err_d;
  logic              aborted_q, aborted_d, rej_q, rej_d;
  logic [1:0]        irq_en_q, irq_en_d;
  logic [31:0]       rdata_q, rdata_d;

  logic wr_ctrl, wr_status, start_req, abort_req;
  logic job_busy, param_we, beat, wdt_expired;
  logic unused_wdata;

  assign wr_ctrl   = cfg_we && (cfg_addr == REG_CTRL);
  assign wr_status = cfg_we && (cfg_addr == REG_STATUS);
  assign start_req = wr_ctrl && cfg_wdata[CTRL_START_BIT];
  assign abort_req = wr_ctrl && cfg_wdata[CTRL_ABORT_BIT];
  // GAP belongs to the job: parameters must stay frozen and START is ignored there too.
  assign job_busy  = (state_q == GEN) || (state_q == GAP) || (state_q == RUN);
  assign param_we  = cfg_we && !job_busy;
  assign beat      = (state_q == RUN) && stream_valid && stream_ready;
  assign unused_wdata = ^cfg_wdata;

`ifdef HV_JOB_CTRL_WATCHDOG_EN
  logic [TMO_W-1:0] timeout_q, timeout_d;

  always_comb begin
    timeout_d = timeout_q;
    if (param_we && cfg_addr == REG_TIMEOUT) timeout_d = cfg_wdata[TMO_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_q <= '1;
    else     timeout_q <= timeout_d;
  end

  hv_job_watchdog #(.TMO_W(TMO_W)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    ((state_q == GAP) || beat),
    .count_en (state_q == RUN),
    .timeout  (timeout_q),
    .expired  (wdt_expired)
  );
`else
  logic [TMO_W-1:0] unused_timeout;
  assign unused_timeout = '0;
  assign wdt_expired    = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets its default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    item_a_d  = item_a_q;
    item_num_d = item_num_q;
    addr_i_d  = addr_i_q;
    addr_j_d  = addr_j_q;
    rem_d     = rem_q;
    beats_d   = beats_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    err_d     = err_q;
    aborted_d = aborted_q;
    rej_d     = rej_q;

    if (param_we) begin
      case (cfg_addr)
        REG_ITEM_NUM: item_num_d = cfg_wdata[ITEM_W-1:0];
        REG_ADDR_I:   addr_i_d   = cfg_wdata[ADDR_W-1:0];
        REG_ADDR_J:   addr_j_d   = cfg_wdata[ADDR_W-1:0];
        REG_REM:      rem_d      = cfg_wdata[REM_W-1:0];
        default:      ;
      endcase
    end
    if (cfg_we && cfg_addr == REG_IRQ_EN) irq_en_d = cfg_wdata[1:0];

    // Clears are applied first so a same-cycle set below wins.
    if (wr_status) begin
      done_d    = done_q    & ~cfg_wdata[STAT_DONE_BIT];
      err_d     = err_q     & ~cfg_wdata[STAT_ERR_BIT];
      aborted_d = aborted_q & ~cfg_wdata[STAT_ABORTED_BIT];
      rej_d     = rej_q     & ~cfg_wdata[STAT_REJ_BIT];
    end

    if (beat && beats_q != '1) beats_d = beats_q + 1'b1;

    if (abort_req) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start_req) begin
            if (item_num_q != '0) begin
              state_d   = GEN;
              item_a_d  = '0;
              beats_d   = '0;
              done_d    = 1'b0;
              err_d     = 1'b0;
              aborted_d = 1'b0;
              rej_d     = 1'b0;
            end else begin
              rej_d = 1'b1;
            end
          end
        end
        GEN: begin
          if (item_a_q == item_num_q) state_d = GAP;
          else                        item_a_d = item_a_q + 1'b1;
        end
        GAP: state_d = RUN;
        RUN: begin
          if (beat && stream_last) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (wdt_expired && !beat) begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Readback of BEATS uses beats_d so a beat accepted alongside cfg_re is included.
  always_comb begin
    rdata_d = rdata_q;
    if (cfg_re) begin
      rdata_d = '0;
      case (cfg_addr)
        REG_STATUS: begin
          rdata_d[2:0]             = state_q;
          rdata_d[STAT_DONE_BIT]    = done_q;
          rdata_d[STAT_ERR_BIT]     = err_q;
          rdata_d[STAT_ABORTED_BIT] = aborted_q;
          rdata_d[STAT_REJ_BIT]     = rej_q;
        end
        REG_ITEM_NUM: rdata_d[ITEM_W-1:0] = item_num_q;
        REG_ADDR_I:   rdata_d[ADDR_W-1:0] = addr_i_q;
        REG_ADDR_J:   rdata_d[ADDR_W-1:0] = addr_j_q;
        REG_REM:      rdata_d[REM_W-1:0]  = rem_q;
        REG_BEATS:    rdata_d[BEAT_W-1:0] = beats_d;
`ifdef HV_JOB_CTRL_WATCHDOG_EN
        REG_TIMEOUT:  rdata_d[TMO_W-1:0]  = timeout_q;
`endif
        REG_IRQ_EN:   rdata_d[1:0]        = irq_en_q;
        default:      ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      item_a_q   <= '0;
      item_num_q <= ITEM_W'(ITEM_NUM_RST);
      addr_i_q   <= ADDR_W'(ADDR_I_RST);
      addr_j_q   <= ADDR_W'(ADDR_J_RST);
      rem_q      <= REM_W'(REM_RST);
      beats_q    <= '0;
      irq_en_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      aborted_q  <= 1'b0;
      rej_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      item_a_q   <= item_a_d;
      item_num_q <= item_num_d;
      addr_i_q   <= addr_i_d;
      addr_j_q   <= addr_j_d;
      rem_q      <= rem_d;
      beats_q    <= beats_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      err_q      <= err_d;
      aborted_q  <= aborted_d;
      rej_q      <= rej_d;
      rdata_q    <= rdata_d;
    end
  end

  // gen/run decode straight from the state flop so reset drops them asynchronously.
  assign gen             = (state_q == GEN);
  assign run             = (state_q == RUN);
  assign busy            = job_busy;
  assign irq             = (done_q && irq_en_q[IRQ_DONE_BIT]) || (err_q && irq_en_q[IRQ_ERR_BIT]);
  assign item_a          = item_a_q;
  assign item_memory_num = item_num_q;
  assign addr_i          = addr_i_q;
  assign addr_j          = addr_j_q;
  assign remainder       = rem_q;
  assign cfg_rdata       = rdata_q;

endmodule

// File: tb/tb_hv_job_ctrl.sv
// Self-checking bench for hv_job_ctrl: randomized jobs, parameter traffic, abort,
// reject and reset scenarios against a register/flag-level reference model.
module tb_hv_job_ctrl;

  localparam int ITEM_W = 16;
  localparam int ADDR_W = 20;
  localparam int REM_W  = 5;
  localparam int BEAT_W = 16;
  localparam int TMO_W  = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we, cfg_re;
  logic [3:0]        cfg_addr;
  logic [31:0]       cfg_wdata, cfg_rdata;
  logic              stream_valid, stream_ready, stream_last;
  logic              gen, run, busy, irq;
  logic [ITEM_W-1:0] item_a, item_memory_num;
  logic [ADDR_W-1:0] addr_i, addr_j;
  logic [REM_W-1:0]  remainder;

  int errors = 0;
  int checks = 0;

  // Reference model: parameter values and status flags.
  int unsigned m_param [4];
  int          m_state;
  bit          m_done, m_err, m_aborted, m_rej;

  always #5 clk = ~clk;

  hv_job_ctrl #(
    .ITEM_W(ITEM_W), .ADDR_W(ADDR_W), .REM_W(REM_W), .BEAT_W(BEAT_W), .TMO_W(TMO_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_we          (cfg_we),
    .cfg_re          (cfg_re),
    .cfg_addr        (cfg_addr),
    .cfg_wdata       (cfg_wdata),
    .cfg_rdata       (cfg_rdata),
    .stream_valid    (stream_valid),
    .stream_ready    (stream_ready),
    .stream_last     (stream_last),
    .gen             (gen),
    .run             (run),
    .item_a          (item_a),
    .item_memory_num (item_memory_num),
    .addr_i          (addr_i),
    .addr_j          (addr_j),
    .remainder       (remainder),
    .busy            (busy),
    .irq             (irq)
  );

  function automatic int unsigned width_of(int idx);
    case (idx)
      0:       return ITEM_W;
      1, 2:    return ADDR_W;
      default: return REM_W;
    endcase
  endfunction

  function automatic int unsigned trunc(int unsigned v, int unsigned w);
    return 32'(64'(v) & ((64'd1 << w) - 64'd1));
  endfunction

  function automatic logic [31:0] status_word(int st, bit d, bit e, bit ab, bit sr);
    return {24'd0, sr, ab, e, d, 1'b0, 3'(st)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
    cfg_re = 1'b1; cfg_addr = a;
    step();
    cfg_re = 1'b0;
    d = cfg_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b1; cfg_we = 0; cfg_re = 0; cfg_addr = '0; cfg_wdata = '0;
    stream_valid = 0; stream_ready = 0; stream_last = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({gen, run, busy, irq} !== 4'b0 || item_a !== '0 || cfg_rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gen=%b run=%b busy=%b irq=%b item_a=%0d rdata=%0h, required all 0",
               gen, run, busy, irq, item_a, cfg_rdata);
    end
    checks++;
    if (item_memory_num !== 16'd1000 || addr_i !== 20'd9 || addr_j !== 20'd2 || remainder !== 5'd0) begin
      errors++;
      $display("FAIL reset_param_ports: got %0d/%0d/%0d/%0d, required 1000/9/2/0",
               item_memory_num, addr_i, addr_j, remainder);
    end
    rst = 1'b0;
    step();
    m_param = '{1000, 9, 2, 0};
    m_state = 0; m_done = 0; m_err = 0; m_aborted = 0; m_rej = 0;
    for (int a = 0; a < 4; a++) begin
      cfg_read(4'(a + 2), rd);
      checks++;
      if (rd !== m_param[a]) begin
        errors++;
        $display("FAIL reset_param_read[%0d]: got %0d, required %0d", a + 2, rd, m_param[a]);
      end
    end
    cfg_read(4'h1, rd);
    checks++;
    if (rd !== status_word(0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_status: got %0h, required 0", rd);
    end
  endtask

  task automatic test_param_rw();
    logic [31:0] rd, d;
    int unsigned a;
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 3);
      d = $urandom;
      cfg_write(4'(a + 2), d);
      m_param[a] = trunc(d, width_of(int'(a)));
    end
    for (int i = 0; i < 4; i++) begin
      cfg_read(4'(i + 2), rd);
      checks++;
      if (rd !== m_param[i]) begin
        errors++;
        $display("FAIL param_readback[%0d]: got %0h, required %0h", i + 2, rd, m_param[i]);
      end
    end
    checks++;
    if (item_memory_num !== m_param[0][ITEM_W-1:0] || addr_i !== m_param[1][ADDR_W-1:0] ||
        addr_j !== m_param[2][ADDR_W-1:0] || remainder !== m_param[3][REM_W-1:0]) begin
      errors++;
      $display("FAIL param_ports: got %0h/%0h/%0h/%0h, required %0h/%0h/%0h/%0h",
               item_memory_num, addr_i, addr_j, remainder, m_param[0], m_param[1], m_param[2], m_param[3]);
    end
    for (int u = 9; u < 16; u++) begin
      cfg_write(4'(u), $urandom);
      cfg_read(4'(u), rd);
      checks++;
      if (rd !== 32'd0) begin
        errors++;
        $display("FAIL unmapped_read[%0d]: got %0h, required 0", u, rd);
      end
    end
    cfg_write(4'h6, 32'hFFFF_FFFF);
    cfg_read(4'h6, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL beats_readonly: got %0h, required 0", rd);
    end
    d = $urandom;
    cfg_write(4'h7, d);
    cfg_read(4'h7, rd);
    checks++;
`ifdef HV_JOB_CTRL_WATCHDOG_EN
    if (rd !== trunc(d, TMO_W)) begin
      errors++;
      $display("FAIL timeout_readback: got %0h, required %0h", rd, trunc(d, TMO_W));
    end
    cfg_write(4'h7, 32'd0);
`else
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL timeout_absent: got %0h, required 0", rd);
    end
`endif
  endtask

  task automatic test_jobs();
    logic [31:0] rd;
    int unsigned n, nb, stalls;
    cfg_write(4'h8, 32'd1);
    for (int it = 0; it < 4; it++) begin
      n  = $urandom_range(1, 6);
      nb = $urandom_range(2, 5);
      cfg_write(4'h2, n);
      m_param[0] = n;
      cfg_write(4'h0, 32'd1);
      m_done = 0; m_err = 0; m_aborted = 0; m_rej = 0;
      for (int k = 0; k <= int'(n); k++) begin
        checks++;
        if ({gen, run, busy} !== 3'b101 || item_a !== k) begin
          errors++;
          $display("FAIL gen_cycle[%0d.%0d]: gen=%b run=%b busy=%b item_a=%0d, required 1/0/1 item_a=%0d",
                   it, k, gen, run, busy, item_a, k);
        end
        step();
      end
      checks++;
      if ({gen, run} !== 2'b00 || item_a !== n) begin
        errors++;
        $display("FAIL gap_cycle[%0d]: gen=%b run=%b item_a=%0d, required 0/0 item_a=%0d", it, gen, run, item_a, n);
      end
      step();
      checks++;
      if ({gen, run, busy} !== 3'b011) begin
        errors++;
        $display("FAIL run_entry[%0d]: gen=%b run=%b busy=%b, required 0/1/1", it, gen, run, busy);
      end
      if (it == 0) cfg_write(4'h3, 32'd5);
      for (int b = 0; b < int'(nb); b++) begin
        stalls = $urandom_range(0, 2);
        for (int s = 0; s < int'(stalls); s++) begin
          stream_valid = 1'($urandom_range(0, 1));
          stream_ready = stream_valid ? 1'b0 : 1'($urandom_range(0, 1));
          stream_last  = 1'($urandom_range(0, 1));
          step();
        end
        stream_valid = 1'b1; stream_ready = 1'b1; stream_last = (b == int'(nb) - 1);
        if (b == 0) begin
          cfg_re = 1'b1; cfg_addr = 4'h6;
        end
        if (b == int'(nb) - 1 && it == 1) begin
          cfg_we = 1'b1; cfg_addr = 4'h1; cfg_wdata = 32'h10;
        end
        step();
        if (b == 0) begin
          cfg_re = 1'b0;
          checks++;
          if (cfg_rdata !== 32'd1) begin
            errors++;
            $display("FAIL beats_same_cycle_read[%0d]: got %0d, required 1", it, cfg_rdata);
          end
        end
        cfg_we = 1'b0; stream_valid = 1'b0; stream_ready = 1'b0; stream_last = 1'b0;
      end
      m_state = 4; m_done = 1;
      checks++;
      if ({gen, run, busy, irq} !== 4'b0001) begin
        errors++;
        $display("FAIL done_outputs[%0d]: gen=%b run=%b busy=%b irq=%b, required 0/0/0/1", it, gen, run, busy, irq);
      end
      cfg_read(4'h1, rd);
      checks++;
      if (rd !== status_word(m_state, m_done, m_err, m_aborted, m_rej)) begin
        errors++;
        $display("FAIL done_status[%0d]: got %0h, required %0h", it, rd,
                 status_word(m_state, m_done, m_err, m_aborted, m_rej));
      end
      cfg_read(4'h6, rd);
      checks++;
      if (rd !== nb) begin
        errors++;
        $display("FAIL beat_count[%0d]: got %0d, required %0d", it, rd, nb);
      end
      if (it == 0) begin
        cfg_read(4'h3, rd);
        checks++;
        if (rd !== m_param[1] || addr_i !== m_param[1][ADDR_W-1:0]) begin
          errors++;
          $display("FAIL busy_write_ignored: got %0h port %0h, required %0h", rd, addr_i, m_param[1]);
        end
        cfg_write(4'h1, 32'h10);
        m_done = 0;
        checks++;
        if (irq !== 1'b0) begin
          errors++;
          $display("FAIL irq_clear: irq=%b, required 0", irq);
        end
      end
    end
  endtask

  task automatic test_start_rej();
    logic [31:0] rd;
    cfg_write(4'h2, 32'd0);
    m_param[0] = 0;
    cfg_write(4'h0, 32'd1);
    m_rej = 1;
    checks++;
    if ({gen, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rej_outputs: gen=%b busy=%b, required 0/0", gen, busy);
    end
    cfg_read(4'h1, rd);
    checks++;
    if (rd !== status_word(m_state, m_done, m_err, m_aborted, m_rej)) begin
      errors++;
      $display("FAIL rej_status: got %0h, required %0h", rd, status_word(m_state, m_done, m_err, m_aborted, m_rej));
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    cfg_write(4'h2, 32'd6);
    m_param[0] = 6;
    cfg_write(4'h0, 32'd2);
    m_state = 0; m_aborted = 1;
    cfg_read(4'h1, rd);
    checks++;
    if (rd !== status_word(m_state, m_done, m_err, m_aborted, m_rej)) begin
      errors++;
      $display("FAIL abort_from_done: got %0h, required %0h", rd, status_word(m_state, m_done, m_err, m_aborted, m_rej));
    end
    cfg_write(4'h0, 32'd3);
    checks++;
    if ({gen, busy} !== 2'b00) begin
      errors++;
      $display("FAIL start_abort_same_write: gen=%b busy=%b, required 0/0", gen, busy);
    end
    cfg_read(4'h1, rd);
    checks++;
    if (rd !== status_word(m_state, m_done, m_err, m_aborted, m_rej)) begin
      errors++;
      $display("FAIL start_abort_status: got %0h, required %0h", rd, status_word(m_state, m_done, m_err, m_aborted, m_rej));
    end
    cfg_write(4'h0, 32'd1);
    m_done = 0; m_err = 0; m_aborted = 0; m_rej = 0;
    step();
    cfg_write(4'h0, 32'd1);
    checks++;
    if (gen !== 1'b1 || item_a !== 16'd2) begin
      errors++;
      $display("FAIL start_while_busy: gen=%b item_a=%0d, required 1 item_a=2", gen, item_a);
    end
    cfg_write(4'h0, 32'd2);
    m_state = 0; m_aborted = 1;
    checks++;
    if ({gen, run, busy} !== 3'b000) begin
      errors++;
      $display("FAIL abort_in_gen: gen=%b run=%b busy=%b, required 0/0/0", gen, run, busy);
    end
    cfg_read(4'h1, rd);
    checks++;
    if (rd !== status_word(m_state, m_done, m_err, m_aborted, m_rej)) begin
      errors++;
      $display("FAIL abort_status: got %0h, required %0h", rd, status_word(m_state, m_done, m_err, m_aborted, m_rej));
    end
  endtask

  task automatic test_reset_midjob();
    logic [31:0] rd;
    cfg_write(4'h2, 32'd1);
    cfg_write(4'h0, 32'd1);
    repeat (3) step();
    checks++;
    if (run !== 1'b1) begin
      errors++;
      $display("FAIL midjob_run: run=%b, required 1", run);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({gen, run, busy} !== 3'b000 || item_memory_num !== 16'd1000) begin
      errors++;
      $display("FAIL async_reset: gen=%b run=%b busy=%b item_num=%0d, required 0/0/0 1000",
               gen, run, busy, item_memory_num);
    end
    step();
    rst = 1'b0;
    step();
    m_param = '{1000, 9, 2, 0};
    m_state = 0; m_done = 0; m_err = 0; m_aborted = 0; m_rej = 0;
    cfg_read(4'h1, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL midjob_reset_status: got %0h, required 0", rd);
    end
    cfg_read(4'h8, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL midjob_reset_irq_en: got %0h, required 0", rd);
    end
  endtask

`ifdef HV_JOB_CTRL_WATCHDOG_EN
  task automatic test_watchdog();
    logic [31:0] rd;
    int cyc;
    cfg_write(4'h8, 32'd2);
    cfg_write(4'h7, 32'd10);
    cfg_write(4'h2, 32'd1);
    cfg_write(4'h0, 32'd1);
    repeat (3) step();
    cyc = 0;
    while (run === 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    // Counter is 0 on the first RUN cycle, so it equals 10 on the 11th.
    checks++;
    if (cyc !== 11) begin
      errors++;
      $display("FAIL watchdog_cycles: run lasted %0d cycles, required 11", cyc);
    end
    m_state = 5; m_err = 1;
    cfg_read(4'h1, rd);
    checks++;
    if (rd !== status_word(m_state, m_done, m_err, m_aborted, m_rej) || irq !== 1'b1) begin
      errors++;
      $display("FAIL watchdog_err: status=%0h irq=%b, required %0h irq=1", rd, irq,
               status_word(m_state, m_done, m_err, m_aborted, m_rej));
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_param_rw();
    test_jobs();
    test_start_rej();
    test_abort();
    test_reset_midjob();
`ifdef HV_JOB_CTRL_WATCHDOG_EN
    test_watchdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
